// File: rtl/mem_stage_ls.sv
// Memory stage with load/store response handling: waits on data_ok, extracts and extends load data,
// buffers responses while WB stalls and drops responses of flushed loads. Optional ID forwarding port: MS_FWD_EN.
module mem_stage_ls #(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned DROP_W          = 2,
    parameter int unsigned ES_TO_MS_BUS_WD = 2*DATA_W+10,
    parameter int unsigned MS_TO_WS_BUS_WD = 2*DATA_W+6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [DATA_W-1:0]          data_sram_rdata,
    input  logic                       ms_flush,
    output logic                       ms_fwd_valid,
    output logic                       ms_fwd_stall,
    output logic [4:0]                 ms_fwd_dest,
    output logic [DATA_W-1:0]          ms_fwd_data
);

    localparam int unsigned OFF_W = $clog2(DATA_W/8);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
    logic                       rbuf_valid;
    logic [DATA_W-1:0]          rbuf_data;
    logic [DROP_W-1:0]          drop_cnt;

    logic [2:0]        ld_op;
    logic              res_from_mem;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc;

    assign ld_op        = es_bus_r[ES_TO_MS_BUS_WD-1 -: 3];
    assign res_from_mem = es_bus_r[ES_TO_MS_BUS_WD-4];
    assign gr_we        = es_bus_r[ES_TO_MS_BUS_WD-5];
    assign dest         = es_bus_r[ES_TO_MS_BUS_WD-6 -: 5];
    assign alu_result   = es_bus_r[2*DATA_W-1 -: DATA_W];
    assign pc           = es_bus_r[DATA_W-1:0];

    logic resp_ok;
    logic ms_ready_go;
    logic load_wait;
    logic drop_dec;
    logic drop_inc;

    // A response is consumable only once all discards for cancelled loads have drained
    assign resp_ok        = data_sram_data_ok && (drop_cnt == '0);
    assign ms_ready_go    = !res_from_mem || rbuf_valid || resp_ok;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
    assign load_wait      = ms_valid && res_from_mem && !rbuf_valid;
    assign drop_dec       = data_sram_data_ok && (drop_cnt != '0);
    assign drop_inc       = ms_flush && load_wait && !resp_ok;

    logic [DATA_W-1:0] ld_raw;
    logic [OFF_W-1:0]  offset;
    logic [OFF_W-1:0]  off_h;
    logic [OFF_W-1:0]  off_w;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       word_v;
    logic [DATA_W-1:0] ld_ext;
    logic [DATA_W-1:0] final_result;

    assign ld_raw = rbuf_valid ? rbuf_data : data_sram_rdata;
    assign offset = alu_result[OFF_W-1:0];

    // Lane select and extension; offset bits below the access size are ignored
    always_comb begin
        off_h  = offset & ~OFF_W'(1);
        off_w  = offset & ~OFF_W'(3);
        byte_v = 8'(ld_raw >> {offset, 3'b000});
        half_v = 16'(ld_raw >> {off_h, 3'b000});
        word_v = 32'(ld_raw >> {off_w, 3'b000});
        ld_ext = DATA_W'($signed(word_v));
        case (ld_op)
            3'b001:  ld_ext = DATA_W'($signed(byte_v));
            3'b010:  ld_ext = DATA_W'(byte_v);
            3'b011:  ld_ext = DATA_W'($signed(half_v));
            3'b100:  ld_ext = DATA_W'(half_v);
            3'b101:  ld_ext = DATA_W'(word_v);
            3'b110:  ld_ext = ld_raw;
            default: ld_ext = DATA_W'($signed(word_v));
        endcase
    end

    assign final_result = res_from_mem ? ld_ext : alu_result;
    assign ms_to_ws_bus = {gr_we && ms_valid, dest, final_result, pc};

    // Pipeline, response buffer and discard counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid   <= 1'b0;
            es_bus_r   <= '0;
            rbuf_valid <= 1'b0;
            rbuf_data  <= '0;
            drop_cnt   <= '0;
        end else begin
            if (ms_flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
                if (es_to_ms_valid) begin
                    es_bus_r <= es_to_ms_bus;
                end
            end

            if (ms_flush || ms_allowin) begin
                rbuf_valid <= 1'b0;
            end else if (load_wait && resp_ok && !ws_allowin) begin
                rbuf_valid <= 1'b1;
                rbuf_data  <= data_sram_rdata;
            end

            if (drop_inc && !drop_dec && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end else if (drop_dec && !drop_inc) begin
                drop_cnt <= drop_cnt - DROP_W'(1);
            end
        end
    end

`ifdef MS_FWD_EN
    assign ms_fwd_valid = ms_valid && gr_we && (dest != 5'd0);
    assign ms_fwd_dest  = dest;
    assign ms_fwd_data  = final_result;
    assign ms_fwd_stall = ms_fwd_valid && res_from_mem && !ms_ready_go;
`else
    assign ms_fwd_valid = 1'b0;
    assign ms_fwd_dest  = 5'd0;
    assign ms_fwd_data  = '0;
    assign ms_fwd_stall = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: directed steps on 32- and 64-bit instances, then random traffic against
// a transaction-level model (expected WB results plus an in-order response queue).
module tb_mem_stage_ls;

    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = 2*DW+10;
    localparam int unsigned OW   = 2*DW+6;
    localparam int unsigned BW64 = 138;
    localparam int unsigned OW64 = 134;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, ws_allowin, ms_flush;
    logic          ms_allowin, es_to_ms_valid, ms_to_ws_valid, data_ok;
    logic [BW-1:0] es_to_ms_bus;
    logic [OW-1:0] ms_to_ws_bus;
    logic [DW-1:0] rdata, fwd_data;
    logic          fwd_valid, fwd_stall;
    logic [4:0]    fwd_dest;

    logic            allowin64, es_valid64, valid64, data_ok64, fv64, fs64;
    logic [BW64-1:0] es_bus64;
    logic [OW64-1:0] ws_bus64;
    logic [63:0]     rdata64, fdata64;
    logic [4:0]      fdest64;

    mem_stage_ls dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .ms_flush(ms_flush),
        .ms_fwd_valid(fwd_valid), .ms_fwd_stall(fwd_stall), .ms_fwd_dest(fwd_dest), .ms_fwd_data(fwd_data)
    );

    mem_stage_ls #(.DATA_W(64)) dut64 (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(allowin64),
        .es_to_ms_valid(es_valid64), .es_to_ms_bus(es_bus64),
        .ms_to_ws_valid(valid64), .ms_to_ws_bus(ws_bus64),
        .data_sram_data_ok(data_ok64), .data_sram_rdata(rdata64), .ms_flush(ms_flush),
        .ms_fwd_valid(fv64), .ms_fwd_stall(fs64), .ms_fwd_dest(fdest64), .ms_fwd_data(fdata64)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] mk_bus(input logic [2:0] op, input logic rfm, input logic we,
                                             input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] p);
        return {op, rfm, we, dst, alu, p};
    endfunction

    // Architectural load result computed arithmetically from the byte address
    function automatic logic [31:0] ld_ref(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
        longint unsigned v;
        int unsigned off;
        off = addr % 4;
        v   = 64'(d);
        case (op)
            3'd1, 3'd2: begin
                v = (v >> (8*off)) & 64'd255;
                if (op == 3'd1 && v >= 128) v = v + 64'hFFFF_FF00;
            end
            3'd3, 3'd4: begin
                v = (v >> (16*(off/2))) & 64'd65535;
                if (op == 3'd3 && v >= 32768) v = v + 64'hFFFF_0000;
            end
            default: v = 64'(d);
        endcase
        return 32'(v);
    endfunction

    task automatic run64(input string tag, input logic [2:0] op, input logic [63:0] alu,
                         input logic [63:0] rd, input logic [63:0] exp);
        es_valid64 = 1'b1;
        es_bus64   = {op, 1'b1, 1'b1, 5'd3, alu, 64'h200};
        tick();
        es_valid64 = 1'b0;
        data_ok64  = 1'b1;
        rdata64    = rd;
        #1;
        chk({tag, "_valid"}, 128'(valid64), 128'(1'b1));
        chk(tag, 128'(ws_bus64[127:64]), 128'(exp));
        tick();
        data_ok64 = 1'b0;
    endtask

    typedef struct {
        logic [31:0] data;
        bit          cancelled;
    } resp_t;

    resp_t         rq[$];
    bit            cur_v, cur_ld, cur_got;
    logic [OW-1:0] cur_bus;

    function automatic int n_cancelled();
        int n = 0;
        foreach (rq[i]) if (rq[i].cancelled) n++;
        return n;
    endfunction

    initial begin
        reset = 1'b1; ws_allowin = 1'b1; ms_flush = 1'b0;
        es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_ok = 1'b0; rdata = '0;
        es_valid64 = 1'b0; es_bus64 = '0; data_ok64 = 1'b0; rdata64 = '0;
        tick();
        tick();
        chk("rst_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        chk("rst_allowin", 128'(ms_allowin), 128'(1'b1));
        chk("rst_bus", 128'(ms_to_ws_bus), 128'(0));
        chk("rst_fwd", 128'({fwd_valid, fwd_stall, fwd_dest, fwd_data}), 128'(0));
        chk("rst_bus64", 128'({valid64, ws_bus64}), 128'(0));
        reset = 1'b0;

        // Non-load passes through in one cycle
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h100);
        #1 chk("add_allowin0", 128'(ms_allowin), 128'(1'b1));
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("add_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        chk("add_bus", 128'(ms_to_ws_bus), 128'({1'b1, 5'd5, 32'h1234_5678, 32'h100}));
        chk("add_allowin", 128'(ms_allowin), 128'(1'b1));
        tick();

        // LB waits for data_ok, then LBU accepted back-to-back
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'd1, 1'b1, 1'b1, 5'd6, 32'h1003, 32'h104);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("lb_wait", 128'(ms_to_ws_valid), 128'(1'b0));
        chk("lb_allowin", 128'(ms_allowin), 128'(1'b0));
        tick();
        data_ok = 1'b1; rdata = 32'h80AA_BBCC;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'd2, 1'b1, 1'b1, 5'd6, 32'h1003, 32'h108);
        #1;
        chk("lb_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        chk("lb_res", 128'(ms_to_ws_bus[63:32]), 128'(32'hFFFF_FF80));
        chk("b2b_allowin", 128'(ms_allowin), 128'(1'b1));
        tick();
        es_to_ms_valid = 1'b0; data_ok = 1'b0;
        #1 chk("lbu_wait", 128'(ms_to_ws_valid), 128'(1'b0));
        tick();
        data_ok = 1'b1;
        #1;
        chk("lbu_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        chk("lbu_res", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_0080));
        tick();
        data_ok = 1'b0;

        // LH response arrives while WB stalls and is held in the buffer
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'd3, 1'b1, 1'b1, 5'd7, 32'h1002, 32'h10C);
        tick();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h8001_7FFF;
        #1;
        chk("lh_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        chk("lh_res", 128'(ms_to_ws_bus[63:32]), 128'(32'hFFFF_8001));
        tick();
        data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rdata = $urandom;
            if (i == 2) ws_allowin = 1'b1;
            #1;
            chk("lh_hold_valid", 128'(ms_to_ws_valid), 128'(1'b1));
            chk("lh_hold_bus", 128'(ms_to_ws_bus), 128'({1'b1, 5'd7, 32'hFFFF_8001, 32'h10C}));
            tick();
        end
        #1 chk("lh_gone", 128'(ms_to_ws_valid), 128'(1'b0));

        // Flushed load's late response is dropped; the next one completes the new load
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd8, 32'h2000, 32'h110);
        tick();
        es_to_ms_valid = 1'b0; ms_flush = 1'b1;
        #1 chk("fl_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        tick();
        ms_flush = 1'b0; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd9, 32'h2004, 32'h114);
        #1 chk("fl_allowin", 128'(ms_allowin), 128'(1'b1));
        tick();
        es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h0000_DEAD;
        #1 chk("drop_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        tick();
        rdata = 32'h0000_BEEF;
        #1;
        chk("beef_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        chk("beef_res", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_BEEF));
        tick();
        data_ok = 1'b0;
        #1 chk("beef_gone", 128'(ms_to_ws_valid), 128'(1'b0));

        // 64-bit datapath lane selection
        run64("lwu64", 3'd5, 64'h1004, 64'hF000_0000_0000_0001, 64'h0000_0000_F000_0000);
        run64("ld64",  3'd6, 64'h1000, 64'hF000_0000_0000_0001, 64'hF000_0000_0000_0001);
        run64("lw64",  3'd0, 64'h1004, 64'hF000_0000_0000_0001, 64'hFFFF_FFFF_F000_0000);
        run64("lb64",  3'd1, 64'h1007, 64'hF000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFF0);

        // Random traffic against the transaction model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur_v = 0; cur_ld = 0; cur_got = 0; cur_bus = '0;
        rq.delete();
        for (int c = 0; c < 3000; c++) begin
            logic [2:0]  op;
            logic        rfm, we, here, ready, e_valid, e_allow, e_fv;
            logic [4:0]  dst;
            logic [31:0] alu, p, ld_data;
            op = 3'($urandom_range(0, 7)); rfm = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1)); dst = 5'($urandom_range(0, 3));
            alu = $urandom; p = $urandom; ld_data = $urandom;
            ws_allowin     = ($urandom_range(0, 3) != 0);
            ms_flush       = ($urandom_range(0, 15) == 0) && (n_cancelled() < 3);
            data_ok        = (rq.size() != 0) && ($urandom_range(0, 2) == 0);
            rdata          = data_ok ? rq[0].data : $urandom;
            es_to_ms_valid = 1'($urandom_range(0, 1));
            es_to_ms_bus   = mk_bus(op, rfm, we, dst, alu, p);
            #1;
            here    = cur_got || (data_ok && rq.size() != 0 && !rq[0].cancelled);
            ready   = !cur_ld || here;
            e_valid = cur_v && ready && !ms_flush;
            e_allow = !cur_v || (ready && ws_allowin);
            chk("rnd_valid", 128'(ms_to_ws_valid), 128'(e_valid));
            chk("rnd_allowin", 128'(ms_allowin), 128'(e_allow));
            if (e_valid) chk("rnd_bus", 128'(ms_to_ws_bus), 128'(cur_bus));
`ifdef MS_FWD_EN
            e_fv = cur_v && cur_bus[OW-1] && (cur_bus[OW-2 -: 5] != 5'd0);
            chk("rnd_fwd_valid", 128'(fwd_valid), 128'(e_fv));
            chk("rnd_fwd_stall", 128'(fwd_stall), 128'(e_fv && cur_ld && !ready));
            if (e_fv) chk("rnd_fwd_dest", 128'(fwd_dest), 128'(cur_bus[OW-2 -: 5]));
            if (e_fv && ready) chk("rnd_fwd_data", 128'(fwd_data), 128'(cur_bus[63:32]));
`else
            e_fv = 1'b0;
            chk("rnd_fwd_off", 128'({fwd_valid, fwd_stall, fwd_dest, fwd_data}), 128'(e_fv));
`endif
            if (data_ok) begin
                if (!rq[0].cancelled) cur_got = 1;
                void'(rq.pop_front());
            end
            if (ms_flush) begin
                if (cur_v && cur_ld && !cur_got) begin
                    foreach (rq[i]) rq[i].cancelled = 1;
                end
                cur_v = 0;
            end else if (e_allow) begin
                cur_v = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    cur_ld  = rfm;
                    cur_got = 0;
                    cur_bus = {we, dst, rfm ? ld_ref(op, alu, ld_data) : alu, p};
                    if (rfm) rq.push_back('{data: ld_data, cancelled: 0});
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
